// File: rtl/router_tx_pkg.sv
// Shared types and defaults for the router output-port transmitter.
package router_tx_pkg;

  localparam int DATA_W_DEF      = 32;
  localparam int ACK_TIMEOUT_DEF = 255;
  localparam int CNT_W           = $clog2(ACK_TIMEOUT_DEF + 1);

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_t;

  // Width of a counter that must reach 'limit' inclusive.
  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/router_oport_ack_tx_if.sv
// Crossbar-side valid/ready input and downstream valid/ack output of the transmitter.
// master = the transmitter itself, slave = crossbar plus downstream peer.
interface router_oport_ack_tx_if
  import router_tx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ack;

  modport master (
    input  in_valid, in_data, out_ack,
    output in_ready, out_valid, out_data
  );

  modport slave (
    output in_valid, in_data, out_ack,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/router_tx_fifo.sv
// Synchronous FIFO exposing head and head+1 so the sender can reload on the pop edge.
// Write-to-readable latency 1 cycle; caller never pushes when full nor pops when empty.
module router_tx_fifo
  import router_tx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_dat,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head_dat,
  output logic [DATA_W-1:0]        next_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  rd_nxt;
  logic [PTR_W:0]    count_q, count_d;

  assign rd_nxt   = rd_ptr_q + PTR_W'(1);
  assign head_dat = mem_q[rd_ptr_q];
  assign next_dat = mem_q[rd_nxt];
  assign count    = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_nxt;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/router_oport_ack_tx.sv
// Output-port sender: buffers crossbar flits, holds each on out_valid/out_data until out_ack.
// Push-to-out_valid 2 cycles; in_ready drops when full; a sticky flag reports a stalled ack.
module router_oport_ack_tx
  import router_tx_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  router_oport_ack_tx_if.master  bus,
  input  logic                   err_clr,
  output logic                   err_timeout,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int WAIT_W = cnt_width(ACK_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(ACK_TIMEOUT);

  tx_state_t         state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;

  logic              push, pop;
  logic [DATA_W-1:0] head_dat, next_dat;
  logic [CW-1:0]     count;

  assign bus.in_ready  = (count < CW'(DEPTH));
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = (state_q == TX_SEND) && bus.out_ack;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign err_timeout   = err_q;
  assign fifo_count    = count;

  router_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (bus.in_data),
    .pop      (pop),
    .head_dat (head_dat),
    .next_dat (next_dat),
    .count    (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= TX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A flit pushed on the final-ack edge is not yet readable, so SEND drains to IDLE first.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TX_IDLE: if (count != '0) state_d = TX_SEND;
      TX_SEND: if (bus.out_ack && count == CW'(1)) state_d = TX_IDLE;
      default: state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = (state_d == TX_SEND);
    out_data_d  = out_data_q;
    if (state_q == TX_IDLE && state_d == TX_SEND) begin
      out_data_d = head_dat;
    end else if (pop && state_d == TX_SEND) begin
      out_data_d = next_dat;
    end

    wait_d = '0;
    if (state_q == TX_SEND && !bus.out_ack) begin
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
    end

    // Set has priority over clear.
    err_d = err_q;
    if (wait_q == WAIT_MAX) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      wait_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_router_oport_ack_tx.sv
// Directed bench: a queue-based model is compared every cycle, plus hand-computed checkpoints.
module tb_router_oport_ack_tx;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       err_clr;
  logic       err_timeout;
  logic [2:0] fifo_count;

  int errs   = 0;
  int checks = 0;

  router_oport_ack_tx_if #(.DATA_W(DW)) bus ();

  router_oport_ack_tx #(
    .DATA_W      (DW),
    .DEPTH       (DEPTH),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .err_clr     (err_clr),
    .err_timeout (err_timeout),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: every accepted flit sits in q until acked; q[0] is on the wire while mv is set.
  logic [DW-1:0] q[$];
  bit            mv;
  int            stall;
  int            old_stall;
  bit            merr;
  bit            acc;
  logic [DW-1:0] acc_dat;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      mv    = 1'b0;
      stall = 0;
      merr  = 1'b0;
    end else begin
      acc       = bus.in_valid && (q.size() < DEPTH);
      acc_dat   = bus.in_data;
      old_stall = stall;
      if (mv) begin
        if (bus.out_ack) begin
          void'(q.pop_front());
          mv    = (q.size() > 0);
          stall = 0;
        end else if (stall < TMO) begin
          stall++;
        end
      end else if (q.size() > 0) begin
        mv = 1'b1;
      end
      if (old_stall == TMO) merr = 1'b1;
      else if (err_clr)     merr = 1'b0;
      if (acc) q.push_back(acc_dat);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("cyc_out_valid", bus.out_valid, mv);
      if (mv) chk("cyc_out_data", bus.out_data, q[0]);
      chk("cyc_fifo_count", fifo_count, q.size());
      chk("cyc_in_ready", bus.in_ready, q.size() < DEPTH);
      chk("cyc_err_timeout", err_timeout, merr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ack  = 1'b0;
    err_clr      = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_err", err_timeout, 1'b0);

    // Single flit, two-cycle latency.
    bus.in_valid = 1'b1; bus.in_data = 32'hA5A5_0001;
    step(); bus.in_valid = 1'b0;
    chk("s1_valid_after_push", bus.out_valid, 1'b0);
    chk("s1_count_after_push", fifo_count, 3'd1);
    step();
    chk("s1_valid_2cyc", bus.out_valid, 1'b1);
    chk("s1_data_2cyc", bus.out_data, 32'hA5A5_0001);
    step();
    chk("s1_data_held", bus.out_data, 32'hA5A5_0001);
    bus.out_ack = 1'b1;
    step(); bus.out_ack = 1'b0;
    chk("s1_valid_after_ack", bus.out_valid, 1'b0);
    chk("s1_count_after_ack", fifo_count, 3'd0);

    // Fill to DEPTH, reject a fifth push, then drain back-to-back.
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.in_data = 32'(i);
      step();
    end
    chk("s2_full_count", fifo_count, 3'd4);
    chk("s2_full_ready", bus.in_ready, 1'b0);
    chk("s2_head", bus.out_data, 32'h1);
    bus.in_data = 32'h5;
    step(); bus.in_valid = 1'b0;
    chk("s2_reject_count", fifo_count, 3'd4);
    bus.out_ack = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      step();
      chk("s2_drain_valid", bus.out_valid, 1'b1);
      chk("s2_drain_data", bus.out_data, 32'(k));
    end
    step(); bus.out_ack = 1'b0;
    chk("s2_drained_valid", bus.out_valid, 1'b0);
    chk("s2_drained_count", fifo_count, 3'd0);

    // Simultaneous push and ack with two entries.
    bus.in_valid = 1'b1; bus.in_data = 32'h11;
    step(); bus.in_data = 32'h22;
    step();
    chk("s3_count_pre", fifo_count, 3'd2);
    bus.in_data = 32'h33; bus.out_ack = 1'b1;
    step(); bus.in_valid = 1'b0;
    chk("s3_count_same", fifo_count, 3'd2);
    chk("s3_next_data", bus.out_data, 32'h22);
    step();
    chk("s3_third_data", bus.out_data, 32'h33);
    step(); bus.out_ack = 1'b0;
    chk("s3_idle", bus.out_valid, 1'b0);

    // Ack timeout, set-over-clear, late ack, then clear.
    bus.in_valid = 1'b1; bus.in_data = 32'h77;
    step(); bus.in_valid = 1'b0;
    step();
    repeat (TMO) step();
    chk("s4_err_before", err_timeout, 1'b0);
    step();
    chk("s4_err_set", err_timeout, 1'b1);
    chk("s4_still_held", bus.out_data, 32'h77);
    chk("s4_still_valid", bus.out_valid, 1'b1);
    err_clr = 1'b1;
    step(); err_clr = 1'b0;
    chk("s4_set_wins", err_timeout, 1'b1);
    bus.out_ack = 1'b1;
    step(); bus.out_ack = 1'b0;
    chk("s4_late_ack_pop", bus.out_valid, 1'b0);
    chk("s4_err_sticky", err_timeout, 1'b1);
    err_clr = 1'b1;
    step(); err_clr = 1'b0;
    chk("s4_err_cleared", err_timeout, 1'b0);

    // Spurious ack in IDLE.
    bus.out_ack = 1'b1;
    repeat (2) step();
    bus.out_ack = 1'b0;
    chk("s5_spur_valid", bus.out_valid, 1'b0);
    chk("s5_spur_count", fifo_count, 3'd0);
    bus.in_valid = 1'b1; bus.in_data = 32'h5A5A_5A5A;
    step(); bus.in_valid = 1'b0;
    step();
    chk("s5_deliver", bus.out_data, 32'h5A5A_5A5A);
    bus.out_ack = 1'b1;
    step(); bus.out_ack = 1'b0;

    // Reset mid-SEND between edges.
    bus.in_valid = 1'b1;
    bus.in_data = 32'hC1; step();
    bus.in_data = 32'hC2; step();
    bus.in_data = 32'hC3; step();
    bus.in_valid = 1'b0;
    chk("s6_pre_count", fifo_count, 3'd3);
    chk("s6_pre_valid", bus.out_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("s6_async_valid", bus.out_valid, 1'b0);
    chk("s6_async_count", fifo_count, 3'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("s6_no_stale", bus.out_valid, 1'b0);
    end
    bus.in_valid = 1'b1; bus.in_data = 32'hD1;
    step(); bus.in_valid = 1'b0;
    step();
    chk("s6_fresh_data", bus.out_data, 32'hD1);
    chk("s6_fresh_count", fifo_count, 3'd1);
    bus.out_ack = 1'b1;
    step(); bus.out_ack = 1'b0;
    chk("s6_fresh_done", bus.out_valid, 1'b0);
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
